vram_fill: RTL and testbench



---
 rtl/vram_fill.sv | 200 ++++++++++++++++++++
 tb/tb_vram_fill.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_fill.sv
// ============================================================================
// vram_fill : VRAM clear-on-reset and full-frame / rectangle fill engine with
//             a drawing-client write port muxed onto the VRAM write bus.
//             Optional abort input enabled by macro VRAM_FILL_ABORT_EN.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module vram_fill #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320,
  parameter int CW     = 16,
  parameter logic [CW-1:0] CLEAR_COLOR = CW'(16'h0000),
  localparam int L  = WIDTH * HEIGHT,
  localparam int AW = $clog2(L),
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] color,
`ifdef VRAM_FILL_ABORT_EN
  input  logic          abort,
`endif
  input  logic          usr_wr_ena,
  input  logic [AW-1:0] usr_wr_addr,
  input  logic [CW-1:0] usr_wr_data,
  output logic          vram_wr_ena,
  output logic [AW-1:0] vram_wr_addr,
  output logic [CW-1:0] vram_wr_data,
  output logic          busy,
  output logic          done,
  output logic          draw_ena
);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_FILL  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [XW-1:0] C_XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] C_YMAX = YW'(HEIGHT - 1);
  localparam logic [AW-1:0] C_LAST = AW'(L - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [XW-1:0] x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
  logic [YW-1:0] y_q, y_d, ymax_q, ymax_d;
  logic [CW-1:0] color_q, color_d;
  logic          busy_q, done_q, draw_ena_q;

  logic          abort_w;
  logic [XW-1:0] xlo_w, xhi_w, nxmin_w, nxmax_w;
  logic [YW-1:0] ylo_w, yhi_w, nymin_w, nymax_w;
  logic [AW-1:0] base_w;

`ifdef VRAM_FILL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Order each corner pair, then clamp both ends into the frame.
  always_comb begin
    xlo_w = (x0 > x1) ? x1 : x0;
    xhi_w = (x0 > x1) ? x0 : x1;
    ylo_w = (y0 > y1) ? y1 : y0;
    yhi_w = (y0 > y1) ? y0 : y1;
    if (mode) begin
      nxmin_w = (xlo_w > C_XMAX) ? C_XMAX : xlo_w;
      nxmax_w = (xhi_w > C_XMAX) ? C_XMAX : xhi_w;
      nymin_w = (ylo_w > C_YMAX) ? C_YMAX : ylo_w;
      nymax_w = (yhi_w > C_YMAX) ? C_YMAX : yhi_w;
    end else begin
      nxmin_w = '0;
      nxmax_w = C_XMAX;
      nymin_w = '0;
      nymax_w = C_YMAX;
    end
    base_w = AW'(32'(nymin_w) * 32'(WIDTH) + 32'(nxmin_w));
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymax_d  = ymax_q;
    color_d = color_q;
    case (state_q)
      S_CLEAR: begin
        if (addr_q == C_LAST) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          xmin_d  = nxmin_w;
          xmax_d  = nxmax_w;
          ymax_d  = nymax_w;
          color_d = color;
          x_d     = nxmin_w;
          y_d     = nymin_w;
          addr_d  = base_w;
        end
      end
      S_FILL: begin
        if (abort_w) begin
          state_d = S_IDLE;
        end else if (x_q == xmax_q) begin
          if (y_q == ymax_q) begin
            state_d = S_DONE;
          end else begin
            // Wrap to the left edge of the next row.
            x_d    = xmin_q;
            y_d    = y_q + YW'(1);
            addr_d = addr_q + AW'(WIDTH) - AW'(xmax_q) + AW'(xmin_q);
          end
        end else begin
          x_d    = x_q + XW'(1);
          addr_d = addr_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymax_q     <= '0;
      color_q    <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      draw_ena_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      xmin_q     <= xmin_d;
      xmax_q     <= xmax_d;
      ymax_q     <= ymax_d;
      color_q    <= color_d;
      busy_q     <= (state_d == S_CLEAR) || (state_d == S_FILL);
      done_q     <= (state_d == S_DONE);
      draw_ena_q <= (state_d == S_IDLE);
    end
  end

  always_comb begin
    vram_wr_ena  = 1'b0;
    vram_wr_addr = '0;
    vram_wr_data = '0;
    case (state_q)
      S_CLEAR: begin
        vram_wr_ena  = 1'b1;
        vram_wr_addr = addr_q;
        vram_wr_data = CLEAR_COLOR;
      end
      S_FILL: begin
        vram_wr_ena  = ~abort_w;
        vram_wr_addr = addr_q;
        vram_wr_data = color_q;
      end
      S_IDLE: begin
        vram_wr_ena  = usr_wr_ena;
        vram_wr_addr = usr_wr_addr;
        vram_wr_data = usr_wr_data;
      end
      default: vram_wr_ena = 1'b0;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign draw_ena = draw_ena_q;

endmodule

`default_nettype wire

// File: tb/tb_vram_fill.sv
// ============================================================================
// tb_vram_fill : self-checking bench for vram_fill on a 5x3 frame.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_vram_fill;

  localparam int          W   = 5;
  localparam int          H   = 3;
  localparam int          L   = W * H;
  localparam logic [15:0] CLR = 16'h001F;

  logic        clk = 1'b0;
  logic        rst, start, mode;
  logic [2:0]  x0, x1;
  logic [1:0]  y0, y1;
  logic [15:0] color;
  logic        usr_wr_ena;
  logic [3:0]  usr_wr_addr;
  logic [15:0] usr_wr_data;
  logic        vram_wr_ena;
  logic [3:0]  vram_wr_addr;
  logic [15:0] vram_wr_data;
  logic        busy, done, draw_ena;
`ifdef VRAM_FILL_ABORT_EN
  logic        abort = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  vram_fill #(.WIDTH(W), .HEIGHT(H), .CW(16), .CLEAR_COLOR(CLR)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
`ifdef VRAM_FILL_ABORT_EN
    .abort(abort),
`endif
    .usr_wr_ena(usr_wr_ena), .usr_wr_addr(usr_wr_addr), .usr_wr_data(usr_wr_data),
    .vram_wr_ena(vram_wr_ena), .vram_wr_addr(vram_wr_addr), .vram_wr_data(vram_wr_data),
    .busy(busy), .done(done), .draw_ena(draw_ena)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Clear model: L back-to-back writes of CLR at 0..L-1, then idle.
  task automatic check_clear;
    for (int i = 0; i < L; i++) begin
`ifdef VRAM_FILL_ABORT_EN
      abort = (i == 3);
      #1;
`endif
      chk("clr_ena",  32'(vram_wr_ena),  32'd1);
      chk("clr_addr", 32'(vram_wr_addr), 32'(i));
      chk("clr_data", 32'(vram_wr_data), 32'(CLR));
      chk("clr_busy", 32'(busy),         32'd1);
      chk("clr_draw", 32'(draw_ena),     32'd0);
      chk("clr_done", 32'(done),         32'd0);
      tick();
    end
`ifdef VRAM_FILL_ABORT_EN
    abort = 1'b0;
    #1;
`endif
    chk("clr_end_draw", 32'(draw_ena),    32'd1);
    chk("clr_end_busy", 32'(busy),        32'd0);
    chk("clr_end_ena",  32'(vram_wr_ena), 32'd0);
  endtask

  // Fill model: order corners, clamp into frame, raster scan x fastest.
  task automatic do_fill(input logic m, input logic [2:0] ax0, input logic [2:0] ax1,
                         input logic [1:0] ay0, input logic [1:0] ay1,
                         input logic [15:0] c, input bit noise);
    int xl, xh, yl, yh;
    if (m) begin
      xl = (ax0 < ax1) ? ax0 : ax1;  xh = (ax0 < ax1) ? ax1 : ax0;
      yl = (ay0 < ay1) ? ay0 : ay1;  yh = (ay0 < ay1) ? ay1 : ay0;
      if (xl > W-1) xl = W-1;
      if (xh > W-1) xh = W-1;
      if (yl > H-1) yl = H-1;
      if (yh > H-1) yh = H-1;
    end else begin
      xl = 0; xh = W-1; yl = 0; yh = H-1;
    end
    start = 1'b1; mode = m; x0 = ax0; x1 = ax1; y0 = ay0; y1 = ay1; color = c;
    tick();
    start = 1'b0;
    if (noise) begin
      start = 1'b1; mode = 1'b1; x0 = 3'd0; x1 = 3'd0; y0 = 2'd0; y1 = 2'd0; color = ~c;
      usr_wr_ena = 1'b1; usr_wr_addr = 4'd14; usr_wr_data = 16'hDEAD;
    end
    #1;
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        chk("fill_ena",  32'(vram_wr_ena),  32'd1);
        chk("fill_addr", 32'(vram_wr_addr), 32'(y * W + x));
        chk("fill_data", 32'(vram_wr_data), 32'(c));
        chk("fill_busy", 32'(busy),         32'd1);
        tick();
      end
    end
    chk("done_pulse", 32'(done),        32'd1);
    chk("done_ena",   32'(vram_wr_ena), 32'd0);
    chk("done_busy",  32'(busy),        32'd0);
    chk("done_draw",  32'(draw_ena),    32'd0);
    start = 1'b0;
    usr_wr_ena = 1'b0;
    tick();
    chk("post_draw", 32'(draw_ena),    32'd1);
    chk("post_done", 32'(done),        32'd0);
    chk("post_ena",  32'(vram_wr_ena), 32'd0);
    tick();
    chk("no_queue_busy", 32'(busy),     32'd0);
    chk("no_queue_draw", 32'(draw_ena), 32'd1);
  endtask

  task automatic user_writes(input int n);
    for (int k = 0; k < n; k++) begin
      usr_wr_ena  = 1'b1;
      usr_wr_addr = 4'($urandom_range(0, L-1));
      usr_wr_data = 16'($urandom);
      #1;
      chk("usr_ena",  32'(vram_wr_ena),  32'd1);
      chk("usr_addr", 32'(vram_wr_addr), 32'(usr_wr_addr));
      chk("usr_data", 32'(vram_wr_data), 32'(usr_wr_data));
      usr_wr_ena = 1'b0;
      #1;
      chk("usr_idle_ena", 32'(vram_wr_ena), 32'd0);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
    usr_wr_ena = 1'b0; usr_wr_addr = '0; usr_wr_data = '0;
    tick(); tick(); tick();
    chk("rst_busy", 32'(busy),     32'd1);
    chk("rst_draw", 32'(draw_ena), 32'd0);
    chk("rst_done", 32'(done),     32'd0);
    rst = 1'b0;
    check_clear();

    user_writes(3);
    do_fill(1'b1, 3'd1, 3'd2, 2'd1, 2'd2, 16'hF800, 1'b0);
    do_fill(1'b1, 3'd2, 3'd1, 2'd2, 2'd1, 16'h07E0, 1'b0);
    do_fill(1'b1, 3'd3, 3'd7, 2'd3, 2'd1, 16'h001F, 1'b0);
    do_fill(1'b1, 3'd4, 3'd4, 2'd0, 2'd0, 16'h1234, 1'b0);
    do_fill(1'b0, 3'd2, 3'd1, 2'd1, 2'd1, 16'hABCD, 1'b1);
    do_fill(1'b1, 3'd0, 3'd3, 2'd0, 2'd2, 16'h5555, 1'b1);

    for (int r = 0; r < 8; r++) begin
      do_fill(($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom),
              2'($urandom), 2'($urandom), 16'($urandom), 1'($urandom));
      user_writes(1);
    end

`ifdef VRAM_FILL_ABORT_EN
    start = 1'b1; mode = 1'b1; x0 = 3'd0; x1 = 3'd4; y0 = 2'd0; y1 = 2'd1; color = 16'hBEEF;
    tick();
    start = 1'b0;
    for (int p = 0; p < 2; p++) begin
      chk("abt_ena",  32'(vram_wr_ena),  32'd1);
      chk("abt_addr", 32'(vram_wr_addr), 32'(p));
      tick();
    end
    abort = 1'b1;
    #1;
    chk("abt_no_write", 32'(vram_wr_ena), 32'd0);
    tick();
    abort = 1'b0;
    #1;
    chk("abt_draw", 32'(draw_ena), 32'd1);
    chk("abt_done", 32'(done),     32'd0);
    chk("abt_busy", 32'(busy),     32'd0);
    tick();
    chk("abt_done2", 32'(done), 32'd0);
`endif

    // Reset in the middle of a fill: no done, clear restarts from 0.
    start = 1'b1; mode = 1'b0; color = 16'h7777;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("rstfill_done", 32'(done), 32'd0);
    chk("rstfill_busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b0;
    check_clear();

    // Reset held several cycles mid-clear restarts at address 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    check_clear();

    do_fill(1'b1, 3'd1, 3'd1, 2'd2, 2'd0, 16'hC0DE, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
